// File: rtl/nios2_status_in_pio.sv
// nios2_status_in_pio: Avalon-MM input PIO with synchronizer, edge capture (W1C) and masked level IRQ
module nios2_status_in_pio #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] s;
  logic [WIDTH-1:0] sync, prev, irq_mask, edge_cap, edge_det, clr;
  logic [31:0] rd_mux;
  logic wr, rd;
  assign sync = s[SYNC_STAGES-1];
  assign wr = chipselect && !write_n;
  assign rd = chipselect && write_n;
  assign irq = |(edge_cap & irq_mask);
  // edge detection, bus-side clear mask and read mux
  always_comb begin
    edge_det = EDGE_TYPE == 0 ? (sync & ~prev) : EDGE_TYPE == 1 ? (~sync & prev) : (sync ^ prev);
    clr = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
    rd_mux = address == 3'd0 ? 32'(sync) :
             address == 3'd2 ? 32'(irq_mask) :
             address == 3'd3 ? 32'(edge_cap) : 32'd0;
  end
  // synchronizer chain and previous-sample register for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s <= '0;
      prev <= '0;
    end else begin
      s <= {s[SYNC_STAGES-2:0], in_port};
      prev <= sync;
    end
  end
  // mask and edge-capture registers; a new edge wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      irq_mask <= (wr && address == 3'd2) ? writedata[WIDTH-1:0] : irq_mask;
      edge_cap <= edge_det | (edge_cap & ~clr);
    end
  end
  // registered read data, held between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else readdata <= rd ? rd_mux : readdata;
  end
endmodule

// File: tb/tb_nios2_status_in_pio.sv
// tb_nios2_status_in_pio: directed self-checking bench for nios2_status_in_pio (all three edge types)
module tb_nios2_status_in_pio;
  logic clk = 0;
  logic reset_n;
  logic [2:0] address;
  logic chipselect, write_n;
  logic [31:0] writedata;
  logic [7:0] in_port;
  logic [31:0] rd0, rd1, rd2;
  logic irq0, irq1, irq2;
  int total = 0, passes = 0, fails = 0;

  always #5 clk = ~clk;

  nios2_status_in_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0));
  nios2_status_in_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd1), .irq(irq1));
  nios2_status_in_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    tick();
    chipselect = 0; write_n = 1; writedata = 0;
  endtask

  task automatic rd(input logic [2:0] a);
    chipselect = 1; write_n = 1; address = a;
    tick();
    chipselect = 0;
  endtask

  initial begin
    reset_n = 0; in_port = 8'hFF; chipselect = 0; write_n = 1; address = 0; writedata = 0;
    tick(3);
    chk("rst_readdata", rd0, 32'h0);
    chk("rst_irq", {31'd0, irq0}, 32'h0);
    reset_n = 1;
    tick(3);
    rd(0); chk("post_rst_data", rd0, 32'hFF);
    rd(2); chk("post_rst_mask", rd0, 32'h0);
    rd(3);
    chk("post_rst_cap_rise", rd0, 32'hFF);
    chk("post_rst_cap_fall", rd1, 32'h0);
    chk("post_rst_cap_any", rd2, 32'hFF);
    chk("post_rst_irq", {31'd0, irq0}, 32'h0);
    in_port = 8'hFE;
    tick(4);
    wr(3, 32'hFF);
    wr(2, 32'h01);
    chk("mask_no_irq", {31'd0, irq0}, 32'h0);
    in_port = 8'hFF;
    tick(2);
    chk("irq_before_k2", {31'd0, irq0}, 32'h0);
    tick();
    chk("irq_at_k2", {31'd0, irq0}, 32'h1);
    rd(3); chk("cap_bit0", rd0, 32'h01);
    wr(3, 32'h01);
    chk("irq_after_w1c", {31'd0, irq0}, 32'h0);
    rd(3); chk("cap_cleared", rd0, 32'h00);
    in_port = 8'hFB;
    tick(4);
    in_port = 8'hFF;
    tick(2);
    wr(3, 32'h04);
    rd(3); chk("collision_set_wins", rd0, 32'h04);
    wr(3, 32'h04);
    rd(3); chk("collision_later_clear", rd0, 32'h00);
    wr(3, 32'hFF);
    in_port = 8'hF7;
    tick(4);
    rd(3);
    chk("fall_rise_type", rd0, 32'h00);
    chk("fall_fall_type", rd1, 32'h08);
    chk("fall_any_type", rd2, 32'h08);
    wr(3, 32'hFF);
    in_port = 8'hFF;
    tick(4);
    rd(3);
    chk("rise_rise_type", rd0, 32'h08);
    chk("rise_fall_type", rd1, 32'h00);
    chk("rise_any_type", rd2, 32'h08);
    wr(3, 32'hFF);
    wr(2, 32'hFFFFFFFF);
    rd(2); chk("mask_width_trunc", rd0, 32'hFF);
    tick(2);
    chk("readdata_hold", rd0, 32'hFF);
    wr(0, 32'hA5); wr(1, 32'hA5); wr(4, 32'hA5); wr(7, 32'hA5);
    rd(0); chk("data_after_bad_wr", rd0, 32'hFF);
    rd(1); chk("dir_reads_0", rd0, 32'h0);
    rd(2); chk("mask_after_bad_wr", rd0, 32'hFF);
    rd(3); chk("cap_after_bad_wr", rd0, 32'h0);
    for (int a = 4; a < 8; a++) begin
      rd(3'(a));
      chk($sformatf("unmapped_%0d", a), rd0, 32'h0);
    end
    in_port = 8'hCF;
    tick(4);
    in_port = 8'hFF;
    tick(4);
    wr(2, 32'h30);
    chk("irq_pre_reset", {31'd0, irq0}, 32'h1);
    rd(3); chk("cap_pre_reset", rd0, 32'h30);
    in_port = 8'h00;
    reset_n = 0;
    #2;
    chk("irq_async_drop", {31'd0, irq0}, 32'h0);
    chk("readdata_async_clr", rd0, 32'h0);
    tick();
    reset_n = 1;
    tick();
    rd(0); chk("mid_rst_data", rd0, 32'h0);
    rd(2); chk("mid_rst_mask", rd0, 32'h0);
    rd(3); chk("mid_rst_cap", rd0, 32'h0);
    chk("mid_rst_irq", {31'd0, irq0}, 32'h0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/nios2_status_in_pio.md
# nios2_status_in_pio

Avalon-MM input PIO that reads a hardware status bus into the NIOS2 system and raises an interrupt on selected edges. It complements the output PIO that starts the hardware timer: peripherals such as the timer "done" flag and UART status lines drive `in_port`. Software polls it or takes the IRQ. The block provides a synchronizer, a level readback, per-bit edge capture with bit-clear, and an interrupt mask.

## Interface
Parameters:
- `WIDTH`, default 8: number of input bits, range 1..32.
- `SYNC_STAGES`, default 2: synchronizer flops per bit, range 2..3.
- `EDGE_TYPE`, default 0: edge to capture. 0 = rising, 1 = falling, 2 = any.

Ports:
- `clk`, in, 1: the single system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `address`, in, 3: word address.
- `chipselect`, in, 1: slave select.
- `write_n`, in, 1: active-low write strobe.
- `writedata`, in, 32: write data.
- `in_port`, in, `WIDTH`: asynchronous status inputs.
- `readdata`, out, 32: registered read data. Bits above `WIDTH` are 0.
- `irq`, out, 1: level interrupt, active high.

## Operation
- Register map, all accesses 32-bit:
  - Address 0, DATA (RO): synchronized `in_port`.
  - Address 1, DIRECTION: reads 0; writes ignored.
  - Address 2, IRQMASK (RW): `WIDTH` bits.
  - Address 3, EDGECAPTURE (R/W1C).
  - Addresses 4–7: read 0; writes ignored.
  - Writes to address 0 are ignored.
- Write strobe is `chipselect && !write_n`. A read is any cycle with `chipselect && write_n`. Reads have no side effects.
- Synchronizer: `s[0]` samples `in_port` each clock; `s[i]` samples `s[i-1]`. The synchronizer output is `sync = s[SYNC_STAGES-1]`. The register `prev` samples `sync` each clock.
- Edge detect is per bit and combinational:
  - Rising: `sync & ~prev`.
  - Falling: `~sync & prev`.
  - Any: `sync ^ prev`.
- EDGECAPTURE bit n:
  - Sets when edge n is detected.
  - Clears on a write to address 3 with `writedata[n] = 1`.
  - If set and clear occur in the same cycle, set wins and the bit stays 1.
  - Writing 0 to a bit has no effect.
- `irq = |(EDGECAPTURE & IRQMASK)`. It is driven combinationally from the registers, so there is no glitch source from `in_port`.
- Reset values: every `s[i]`, `prev`, IRQMASK, EDGECAPTURE and `readdata` = 0; `irq` = 0.
- `prev` resets to 0. As a result, an input held high across reset release is captured as a rising (or any) edge once it passes the synchronizer.
- Reset asserted mid-operation clears all state immediately, including pending captures.

## Timing
- `in_port` bit stable before rising edge k:
  - `sync` reflects it after edge k+SYNC_STAGES-1.
  - EDGECAPTURE sets at edge k+SYNC_STAGES.
  - `irq` rises in the same cycle as EDGECAPTURE if the bit is masked in.
- Read latency is 1, fixed:
  - Address is sampled at edge t.
  - `readdata` is valid after edge t and holds until the next read.
  - In non-read cycles, `readdata` holds its value.
- Write takes effect at the sampling edge t.
  - A read of the same register issued in cycle t+1 returns the new value.
  - An IRQMASK change affects `irq` from the cycle after edge t.
- Pulses shorter than one clock period may be missed. No stretching is provided.
- Back-to-back reads and writes are supported every cycle. There is no waitrequest.

## Test plan
- **Reset.** Hold `reset_n` = 0 with `in_port` = 0xFF, release it, then read addresses 0, 2, 3.
  - DATA = 0xFF after SYNC_STAGES+1 cycles.
  - IRQMASK = 0.
  - EDGECAPTURE = 0xFF (EDGE_TYPE = 0).
  - `irq` = 0.
- **Rising capture and IRQ.** Write IRQMASK = 0x01. Drive `in_port[0]` 0→1 before edge k.
  - EDGECAPTURE bit 0 sets at k+2 (SYNC_STAGES = 2).
  - `irq` = 1 from the same cycle.
  - Write 0x01 to address 3: `irq` drops the next cycle and EDGECAPTURE reads 0x00.
- **Set/clear collision.** Time a W1C write to address 3 = 0x04 on the same edge that bit 2 detects a new rising edge.
  - Bit 2 reads 1 afterward.
  - A later W1C clears it.
- **EDGE_TYPE variants.** Toggle `in_port[3]` 1→0→1.
  - EDGE_TYPE = 1: only the falling edge captures.
  - EDGE_TYPE = 2: both edges capture; bit cleared between toggles.
- **Bus decode.**
  - Write 0xA5 to addresses 0, 1, 4, 7: no state change.
  - Reads of addresses 1 and 4–7 return 0.
  - Bits [31:WIDTH] of every read are 0.
  - Read of address 2 after writing 0xFFFFFFFF returns 0x000000FF.
- **Reset mid-capture.**
  - Set EDGECAPTURE = 0x30 and IRQMASK = 0x30, then pulse `reset_n` low for 1 cycle.
  - `irq` drops asynchronously, and all registers read 0 (given `in_port` = 0).
